// File: rtl/bus_pkg.sv
// bus_pkg: shared FSM states, access kinds and open-bus default
// for the bus_target responder and its RAM.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    READ,
    WRITE,
    ILLEGAL
  } kind_t;

  localparam logic [7:0] OPEN_BUS_DEF = 8'hFF;

endpackage

// File: rtl/bus_target_ram.sv
// bus_ram: single-port array, sync write on we, comb read by idx.
// Ports: clk, we, idx, wdata in; rdata out.
module bus_ram #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/bus_target.sv
// bus_target: RAM-window responder for the CPU read/write/done bus.
// Ports: clk, rst_n, bus_address/data_wr/read/write, err_clr in; bus_data_rd/done/err out.
module bus_target
  import bus_pkg::*;
#(
  parameter int                 ADDR_W      = 16,
  parameter int                 DATA_W      = 8,
  parameter logic [ADDR_W-1:0]  RAM_BASE    = '0,
  parameter int                 RAM_DEPTH   = 256,
  parameter int                 WAIT_CYCLES = 1,
  parameter logic [DATA_W-1:0]  OPEN_BUS    = DATA_W'(OPEN_BUS_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] bus_address,
  input  logic [DATA_W-1:0] bus_data_wr,
  input  logic              bus_read,
  input  logic              bus_write,
  output logic [DATA_W-1:0] bus_data_rd,
  output logic              bus_done,
  output logic              bus_err,
  input  logic              err_clr
);

  localparam int IDX_W = $clog2(RAM_DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(RAM_DEPTH);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t            state_q, state_d;
  kind_t             kind_q, kind_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_d;
  logic              done_d, err_d;

  logic [ADDR_W-1:0] off;
  logic              mapped;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_we;

  // offset wraps modulo 2**ADDR_W, so addresses below the base are unmapped
  assign off    = addr_q - RAM_BASE;
  assign mapped = {1'b0, off} < DEPTH_L;
  assign idx    = off[IDX_W-1:0];

  bus_ram #(
    .DEPTH  (RAM_DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .idx   (idx),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = bus_data_rd;
    done_d  = bus_done;
    err_d   = bus_err & ~err_clr;
    ram_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus_read || bus_write) begin
          addr_d  = bus_address;
          wdata_d = bus_data_wr;
          cnt_d   = WAIT_LD;
          kind_d  = (bus_read && bus_write) ? ILLEGAL
                  : (bus_write ? WRITE : READ);
          state_d = (WAIT_CYCLES == 0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DONE;
      end
      DONE: begin
        // first DONE edge (bus_done still low) performs the access
        if (!bus_done) begin
          done_d = 1'b1;
          if (kind_q == ILLEGAL || !mapped) begin
            err_d = 1'b1;
            if (kind_q != WRITE) rdata_d = OPEN_BUS;
          end else if (kind_q == WRITE) begin
            ram_we = 1'b1;
          end else begin
            rdata_d = ram_rdata;
          end
        end else if (!bus_read && !bus_write) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      kind_q      <= READ;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      bus_data_rd <= '0;
      bus_done    <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      bus_data_rd <= rdata_d;
      bus_done    <= done_d;
      bus_err     <= err_d;
    end
  end

endmodule

// File: doc/bus_target.md
# bus_target

Parametrised bus responder for the CPU's read/write/done handshake. It replaces the fixed-response stub in the SoC top level with a real target:
- a RAM window with configurable base and depth, and configurable wait states;
- an open-bus value for unmapped addresses;
- a sticky error flag for illegal or unmapped accesses.

It sits between the CPU bus ports and the SoC memory map.

## Interface
- ADDR_W, 16, bus address width
- DATA_W, 8, bus data width
- RAM_BASE, 16'h0000, first address of RAM window
- RAM_DEPTH, 256, RAM words; power of two, 2..2**ADDR_W
- WAIT_CYCLES, 1, extra cycles before bus_done; 0..15
- OPEN_BUS, 8'hFF, read data for unmapped/illegal access
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- bus_address  in  ADDR_W  CPU address
- bus_data_wr  in  DATA_W  CPU write data
- bus_read  in  1  CPU read request, level
- bus_write  in  1  CPU write request, level
- bus_data_rd  out  DATA_W  read data to CPU, valid while bus_done=1
- bus_done  out  1  access complete
- bus_err  out  1  sticky error flag
- err_clr  in  1  clears bus_err

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE
  - Request = bus_read or bus_write high at a rising edge.
  - Latch address, write data and kind. Load the wait counter with WAIT_CYCLES.
  - If WAIT_CYCLES=0, go directly to DONE; otherwise go to WAIT.
- WAIT
  - Decrement the counter; go to DONE when it reaches 0.
  - Inputs are ignored; the latched request is used.
- Entry to DONE (single edge) performs the access:
  - Write: commit to RAM if mapped.
  - Read: bus_data_rd <= RAM[idx] if mapped, else OPEN_BUS.
  - bus_done <= 1.
- DONE
  - Hold bus_done and bus_data_rd until bus_read=0 and bus_write=0 at an edge.
  - Then bus_done <= 0 and go to IDLE.
- Decode: off = bus_address − RAM_BASE, ADDR_W-bit modular. Mapped iff off < RAM_DEPTH. idx = off[$clog2(RAM_DEPTH)-1:0].
- Unmapped access: write discarded, read returns OPEN_BUS, bus_err set on DONE entry.
- Both bus_read and bus_write high in IDLE: illegal.
  - No RAM access; bus_data_rd = OPEN_BUS; bus_done still asserted (no deadlock); bus_err set.
- Abort: request dropped during WAIT. The access still completes, including any write. DONE sees the request low and exits next edge, so bus_done is high for exactly one cycle.
- bus_err: set on error, cleared by err_clr; a same-cycle set and clear resolves to set.

## Timing
- Reset (async): state=IDLE, bus_done=0, bus_data_rd=0, bus_err=0, counter=0. RAM contents are not reset.
- Reset mid-access: abandoned immediately. A write is committed only if the DONE-entry edge occurred before reset assertion.
- Latency: request sampled at edge N → bus_done high after edge N+1+WAIT_CYCLES.
- Release: request low at edge M → bus_done low after edge M.
- The earliest next request is sampled at edge M+1; there is at least 1 IDLE cycle between accesses.
- bus_data_rd changes only on DONE entry. It holds its last value otherwise.

## Structure
- Shared package bus_pkg holds:
  - the state enum (IDLE/WAIT/DONE);
  - the access-kind enum (READ/WRITE/ILLEGAL);
  - the default OPEN_BUS constant.
- Sub-module bus_ram: single-port array, parameters DEPTH and DATA_W.
  - Synchronous write on the we strobe.
  - Combinational read by idx; the registered output lives in bus_target.

## Test plan
- WAIT_CYCLES=1, write 8'hA5 @16'h0010, then read 16'h0010 → bus_done 2 cycles after each request; read data 8'hA5; bus_err=0.
- WAIT_CYCLES=0, RAM_BASE=16'h8000, RAM_DEPTH=256, read 16'h80FF then 16'h8100 → first returns stored data; second returns 8'hFF and bus_err=1.
- Write to 16'h0020 with request dropped mid-WAIT (WAIT_CYCLES=3) → bus_done single-cycle pulse; later read of 16'h0020 returns the written byte.
- bus_read=bus_write=1 in IDLE → bus_done asserted, bus_data_rd=8'hFF, bus_err=1, RAM unchanged. Then err_clr=1 → bus_err=0. err_clr concurrent with a new error → bus_err stays 1.
- CPU holds bus_read 5 cycles past bus_done → bus_done and bus_data_rd stable throughout; falls after the release edge; next request is not sampled until one cycle later.
- rst_n low during WAIT of a write → outputs go to 0 immediately; FSM in IDLE; write not committed (verified by a later read).
